// File: rtl/blur_pkg.sv
// blur_pkg: frame geometry defaults shared with image_blur, sequencer state
// encoding and small sizing helpers.
package blur_pkg;

    localparam int DEF_WIDTH    = 20;
    localparam int DEF_HEIGHT   = 12;
    localparam int DEF_CHANNELS = 3;

    // Sequencer states.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_STREAM    = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_SKIP      = 3'd4;
    localparam logic [2:0] ST_DRAIN     = 3'd5;
    localparam logic [2:0] ST_ACK       = 3'd6;
    localparam logic [2:0] ST_ERR       = 3'd7;

    // Bytes moved per frame in each direction.
    function automatic int frame_bytes(input int width, input int height, input int channels);
        return width * height * channels;
    endfunction

    localparam int DEF_BYTES = frame_bytes(DEF_WIDTH, DEF_HEIGHT, DEF_CHANNELS);

    // Bits needed to hold values 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/blur_seq_watchdog.sv
// blur_seq_watchdog: counts consecutive enabled cycles and flags the cycle in
// which the count reaches TIMEOUT_CYC. Only built with BLUR_SEQ_TIMEOUT_EN.
module blur_seq_watchdog
    import blur_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int               CNT_W = clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles, holding at the terminal value until cleared.
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + CNT_W'(1);
    end

    // The TIMEOUT_CYC-th enabled cycle is the one that fires.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/blur_frame_sequencer.sv
// blur_frame_sequencer: per-frame sequencing of one image_blur engine.
// Streams a source frame into the engine, waits for done, then drains the
// result into the destination frame RAM.
// Build option: define BLUR_SEQ_TIMEOUT_EN to add a WAIT_DONE watchdog that
// aborts the frame with a frame_err pulse after TIMEOUT_CYC cycles.
module blur_frame_sequencer
    import blur_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_req,
    output logic              frame_busy,
    output logic              frame_ack,
    output logic              frame_err,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic              eng_start,
    output logic [7:0]        eng_image_in,
    input  logic              eng_done,
    input  logic [7:0]        eng_image_out,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [7:0]        dst_data
);

    localparam int                BYTES = frame_bytes(WIDTH, HEIGHT, CHANNELS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BYTES - 1);

    // Reject geometries whose frame does not fit the address space.
    if ((1 << ADDR_W) < BYTES || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("blur_frame_sequencer: ADDR_W too small for frame, or TIMEOUT_CYC < 1");
    end

    logic [2:0]        state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              cnt_last;
    logic              timeout;
    logic              rd_stream;

    assign cnt_last = (cnt == LAST);

`ifdef BLUR_SEQ_TIMEOUT_EN
    blur_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .enable  (state == ST_WAIT_DONE),
        .clear   (state != ST_WAIT_DONE),
        .expired (timeout)
    );
    assign frame_err = (state == ST_ERR);
`else
    assign timeout   = 1'b0;
    assign frame_err = 1'b0;
`endif

    // Next-state decode; done takes priority over a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (frame_req) state_nxt = ST_FETCH;
            ST_FETCH:     state_nxt = ST_STREAM;
            ST_STREAM:    if (cnt_last) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (eng_done) state_nxt = ST_SKIP;
                          else if (timeout) state_nxt = ST_ERR;
            ST_SKIP:      state_nxt = ST_DRAIN;
            ST_DRAIN:     if (cnt_last) state_nxt = ST_ACK;
            default:      state_nxt = ST_IDLE;   // ACK, ERR
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Byte counter: zeroed on each state change, steps through STREAM/DRAIN.
    always_ff @(posedge clk) begin
        if (reset || state_nxt != state)
            cnt <= '0;
        else if (state == ST_STREAM || state == ST_DRAIN)
            cnt <= cnt + ADDR_W'(1);
    end

    // Reads run one byte ahead of the engine; the last STREAM cycle issues
    // no read so the address never steps past the frame.
    assign rd_stream    = (state == ST_STREAM) && !cnt_last;
    assign src_rd_en    = (state == ST_FETCH) || rd_stream;
    assign src_addr     = rd_stream ? cnt + ADDR_W'(1) : '0;

    assign frame_busy   = (state != ST_IDLE);
    assign frame_ack    = (state == ST_ACK);
    assign eng_start    = (state == ST_STREAM);
    assign eng_image_in = src_data;
    assign dst_wr_en    = (state == ST_DRAIN);
    assign dst_addr     = dst_wr_en ? cnt : '0;
    assign dst_data     = eng_image_out;

endmodule
